// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner slice.
//   ROWS/COLS   : matrix geometry (4x4)
//   KEY_W       : width of a key index (row*4+col)
//   key_event_t : queued event {code, press}
//   row_drive() : active-low one-cold row pattern for a row index
//   key_of()    : key index from row and column
package keypad_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned NKEYS = ROWS * COLS;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned COL_W = 2;

  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             press;
  } key_event_t;

  function automatic logic [ROWS-1:0] row_drive(input logic [ROW_W-1:0] idx);
    return ~(ROWS'(1) << idx);
  endfunction

  function automatic logic [KEY_W-1:0] key_of(input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Event queue for the keypad scanner.
//   clk, rst : clock, asynchronous active-high reset (empties the queue)
//   push/din : enqueue request and data; ignored when full unless pop is high
//   pop      : dequeue the head (caller guarantees not empty)
//   dout     : head entry, read combinationally from storage
//   full     : no free entry
//   empty    : no valid entry
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  key_event_t din,
  output key_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  key_event_t     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           wr_en;
  logic           rd_en;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full queue still lands when the head leaves this cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with per-key debounce and an event queue.
//   clk, rst    : clock, asynchronous active-high reset
//   rows        : active-low row drive, one row low per slot of SCAN_DIV cycles
//   cols        : active-low column sense (asynchronous, synchronized here)
//   key_state   : debounced pressed map, bit = row*4+col
//   event_valid : queue head valid
//   event_ready : consumer accepts head
//   event_code  : head key index
//   event_press : head direction (1 press, 0 release)
//   overflow    : sticky, an event was dropped on a full queue
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_SCANS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROWS-1:0]   rows,
  input  logic [COLS-1:0]   cols,
  output logic [NKEYS-1:0]  key_state,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [KEY_W-1:0]  event_code,
  output logic              event_press,
  output logic              overflow
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEB_W = 4;

  logic [COLS-1:0]              cols_s1;
  logic [COLS-1:0]              cols_s2;
  logic [COLS-1:0]              raw_pressed;
  logic [CNT_W-1:0]             slot_cnt;
  logic [ROW_W-1:0]             row_idx;
  logic                         slot_last;
  logic [NKEYS-1:0][DEB_W-1:0]  deb_cnt;

  // Events found by one sample, drained lowest column first.
  logic [COLS-1:0]              pend_valid;
  logic [COLS-1:0]              pend_press;
  logic [ROW_W-1:0]             pend_row;
  logic                         push;
  logic [COL_W-1:0]             push_col;
  key_event_t                   push_event;

  logic                         pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  key_event_t                   head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_s1 <= '1;
      cols_s2 <= '1;
    end else begin
      cols_s1 <= cols;
      cols_s2 <= cols_s1;
    end
  end

  assign raw_pressed = ~cols_s2;
  assign slot_last   = (slot_cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      row_idx  <= '0;
      rows     <= row_drive('0);
    end else if (slot_last) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + ROW_W'(1);
      rows     <= row_drive(row_idx + ROW_W'(1));
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    push     = 1'b0;
    push_col = '0;
    // Descending walk so the lowest pending column wins.
    for (int unsigned c = COLS; c > 0; c--) begin
      if (pend_valid[c-1]) begin
        push     = 1'b1;
        push_col = COL_W'(c - 1);
      end
    end
    push_event.code  = key_of(pend_row, push_col);
    push_event.press = pend_press[push_col];
  end

  // Pending events always drain within 4 cycles, well before the next
  // sample (SCAN_DIV >= 8), so clear-on-push never collides with a set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_state  <= '0;
      deb_cnt    <= '0;
      pend_valid <= '0;
      pend_press <= '0;
      pend_row   <= '0;
    end else begin
      if (push) pend_valid[push_col] <= 1'b0;
      if (slot_last) begin
        pend_row <= row_idx;
        for (int unsigned c = 0; c < COLS; c++) begin
          if (raw_pressed[c] == key_state[key_of(row_idx, COL_W'(c))]) begin
            deb_cnt[key_of(row_idx, COL_W'(c))] <= '0;
          end else if (deb_cnt[key_of(row_idx, COL_W'(c))] == DEB_W'(DEB_SCANS - 1)) begin
            key_state[key_of(row_idx, COL_W'(c))] <= raw_pressed[c];
            deb_cnt[key_of(row_idx, COL_W'(c))]   <= '0;
            pend_valid[c] <= 1'b1;
            pend_press[c] <= raw_pressed[c];
          end else begin
            deb_cnt[key_of(row_idx, COL_W'(c))] <=
              deb_cnt[key_of(row_idx, COL_W'(c))] + DEB_W'(1);
          end
        end
      end
    end
  end

  assign event_valid = !fifo_empty;
  assign pop         = event_valid && event_ready;
  assign event_code  = head.code;
  assign event_press = head.press;

  keypad_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_event),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives cols
// from rows, a behavioural model predicts debounced state and the event
// stream, and a monitor checks outputs against a scoreboard queue.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned DEB      = 2;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] key_state;
  logic        event_valid;
  logic        event_ready;
  logic [3:0]  event_code;
  logic        event_press;
  logic        overflow;

  logic [15:0] pressed;
  bit          rand_ready;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_scanner #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_SCANS  (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rows        (rows),
    .cols        (cols),
    .key_state   (key_state),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_code  (event_code),
    .event_press (event_press),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key pulls its column low when its row is driven.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
  end

  typedef struct {
    int code;
    bit press;
  } ev_t;

  // Reference model state.
  int unsigned phase;
  int unsigned slot_row;
  bit [15:0]   m_state;
  int unsigned m_cnt [16];
  int          m_occ;
  bit          m_ovf;
  ev_t         m_pend [$];
  ev_t         sb [$];

  always @(posedge clk or posedge rst) begin
    bit  do_pop;
    ev_t e;
    int  k;
    bit  raw;
    if (rst) begin
      phase = 0;
      slot_row = 0;
      m_state = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_occ = 0;
      m_ovf = 0;
      m_pend.delete();
      sb.delete();
    end else begin
      do_pop = (m_occ > 0) && event_ready;
      if (do_pop) m_occ--;
      if (m_pend.size() > 0) begin
        e = m_pend.pop_front();
        if (m_occ < DEPTH) begin
          m_occ++;
          sb.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (phase == SCAN_DIV - 1) begin
        for (int c = 0; c < 4; c++) begin
          k   = int'(slot_row) * 4 + c;
          raw = pressed[k];
          if (raw == m_state[k]) begin
            m_cnt[k] = 0;
          end else begin
            m_cnt[k]++;
            if (m_cnt[k] == DEB) begin
              m_state[k] = raw;
              m_cnt[k]   = 0;
              m_pend.push_back('{k, raw});
            end
          end
        end
        phase = 0;
        slot_row = (slot_row + 1) % 4;
      end else begin
        phase++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled between the input-drive point and the next rising edge.
  initial begin
    logic [3:0] exp_rows;
    ev_t        h;
    forever begin
      @(negedge clk);
      #2;
      exp_rows = 4'hF ^ (4'(1) << slot_row);
      check("rows", 32'(rows), 32'(exp_rows));
      check("key_state", 32'(key_state), 32'(m_state));
      check("event_valid", 32'(event_valid), 32'(m_occ > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (event_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'(event_code), 32'hFFFF_FFFF);
        end else begin
          h = sb[0];
          check("event_code", 32'(event_code), 32'(h.code));
          check("event_press", 32'(event_press), 32'(h.press));
          if (event_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ready) event_ready = ($urandom % 4) != 0;
    end
  endtask

  task automatic wait_slot(input int unsigned r, input int unsigned ph);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rand_ready) event_ready = ($urandom % 4) != 0;
      if (slot_row == r && phase == ph) return;
    end
    check("wait_slot_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    pressed = '0;
    event_ready = 1'b1;
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cycles(40);

    // Single key press and release.
    wait_slot(0, 1);
    pressed = 16'h0020;
    cycles(128);
    wait_slot(0, 1);
    pressed = '0;
    cycles(128);

    // One-slot glitch on key 5.
    wait_slot(1, 1);
    pressed = 16'h0020;
    wait_slot(2, 1);
    pressed = '0;
    cycles(64);

    // Two keys in one row.
    wait_slot(0, 1);
    pressed = 16'h0900;
    cycles(96);
    wait_slot(0, 1);
    pressed = '0;
    cycles(96);

    // Five presses with the consumer stalled.
    event_ready = 1'b0;
    wait_slot(0, 1);
    pressed = 16'h1113;
    cycles(96);
    event_ready = 1'b1;
    cycles(20);
    pressed = '0;
    cycles(96);

    // Reset in the middle of a two-event serial push.
    wait_slot(0, 1);
    pressed = 16'h000C;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (m_pend.size() == 1) hit = 1'b1;
    end
    check("serial_push_seen", 32'(hit), 32'd1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(96);
    pressed = '0;
    cycles(96);

    // Random key patterns with a randomly stalling consumer.
    rand_ready = 1'b1;
    repeat (30) begin
      wait_slot($urandom % 4, 1);
      pressed = 16'($urandom & $urandom & $urandom);
      cycles(8 * int'($urandom_range(1, 12)));
    end
    rand_ready = 1'b0;
    event_ready = 1'b1;
    pressed = '0;
    cycles(200);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, meaning clk cycles per row slot (legal range 8..65535).
REQ-002 Parameter DEB_SCANS, default 4, meaning consecutive disagreeing samples needed to flip a key's debounced state (legal range 1..15).
REQ-003 Parameter FIFO_DEPTH, default 4, meaning event queue entries (power of two, at least 2).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rows  output  4  keypad row drive, active-low; exactly one bit low at all times.
REQ-007 cols  input  4  keypad column sense, active-low (external pull-ups), asynchronous to clk.
REQ-008 key_state  output  16  debounced pressed map; bit index = row*4+col.
REQ-009 event_valid  output  1  head of event queue is valid.
REQ-010 event_ready  input  1  consumer accepts head when high together with event_valid.
REQ-011 event_code  output  4  key index of head event (row*4+col).
REQ-012 event_press  output  1  1 = press, 0 = release.
REQ-013 overflow  output  1  sticky; an event was dropped because the queue was full.

Function
REQ-014 cols SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; row index SHALL advance (3 wraps to 0) on the cycle the counter wraps.
REQ-016 rows SHALL equal ~(1 << row_index), registered, changing only at slot boundaries.
REQ-017 Sampling SHALL occur once per slot, at counter = SCAN_DIV-1, for the 4 keys of the current row (raw pressed = ~sync_cols[c]).
REQ-018 Per key, sample equal to debounced state SHALL clear that key's debounce counter.
REQ-019 Per key, sample differing SHALL increment its counter; when the count reaches DEB_SCANS, debounced state SHALL toggle, counter SHALL clear, and one event SHALL be queued.
REQ-020 key_state SHALL update on the cycle after the sample cycle.
REQ-021 Events from one sample SHALL be pushed serially, one per cycle, ascending column order, during cycles 0..3 of the following slot.
REQ-022 Queue SHALL be FIFO; head is presented combinationally from storage; pop occurs when event_valid and event_ready.
REQ-023 Push when full without a same-cycle pop SHALL drop the new event and set overflow; push and pop in the same cycle when full SHALL both succeed.
REQ-024 event_valid SHALL go high the cycle after the first push into an empty queue.
REQ-025 Multiple simultaneously pressed keys (including ghosting patterns) SHALL be reported as sampled; no ghost rejection.
REQ-026 event_code/event_press SHALL remain stable while event_valid is high and event_ready is low.

Reset
REQ-027 rst asserted SHALL force within the same cycle: rows = 4'b1110, slot counter 0, row index 0, all debounce counters 0, key_state 0, queue empty (event_valid 0), overflow 0, synchronizer flops 1 (released).
REQ-028 rst asserted mid-slot or mid-serial-push SHALL discard pending events; scanning restarts at row 0, counter 0, on the first clk edge after deassertion.
REQ-029 overflow SHALL clear only by rst.

Structure
REQ-030 Shared package keypad_pkg SHALL hold ROWS=4, COLS=4, KEY_W=4, and the event struct {code[3:0], press}.
REQ-031 The queue SHALL be sub-module keypad_event_fifo (push/pop/full/empty, parameter FIFO_DEPTH).
REQ-032 Block outputs event_press/event_code in the form used by the LED matrix controller's button inputs via a per-key pulse decode outside this block.

Verification (bench uses SCAN_DIV=8, DEB_SCANS=2, FIFO_DEPTH=4)
REQ-033 Reset release, cols=4'hF -> rows cycles 1110,1101,1011,0111 every 8 cycles; key_state 0; no events.
REQ-034 Hold key 5 (row1,col1) pressed for 4 full scans -> key_state[5]=1 after second row-1 sample; exactly one event {code 5, press 1}; release -> one event {code 5, press 0}.
REQ-035 Key 5 glitch pressed for one row-1 slot only -> no event, key_state unchanged.
REQ-036 Keys 8 and 11 pressed together, event_ready=1 -> events code 8 then code 11 on consecutive cycles.
REQ-037 event_ready=0, 5 distinct presses -> 4 queued in order, overflow=1, fifth dropped; then ready=1 drains exactly 4.
REQ-038 rst pulse during serial push of 2 events -> queue empty, overflow 0, rows=1110, no stale event after release.
